// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and PC-sequencing unit for a 5-stage pipeline.
// Tracks EX/MEM/WB destinations in a small scoreboard and owns the fetch PC.
module pipe_hazard_unit #(
  parameter int unsigned AW      = 12,
  parameter int unsigned RW      = 3,
  parameter int unsigned CW      = 16,
  parameter bit          R0_ZERO = 1'b0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          exec,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_use1,
  input  logic          id_use2,
  input  logic          id_wr,
  input  logic [RW-1:0] id_rd,
  input  logic          id_load,
  input  logic          id_halt,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic [AW-1:0] pc,
  output logic          if_id_en,
  output logic          id_ex_bubble,
  output logic          flush,
  output logic [1:0]    fwd1_sel,
  output logic [1:0]    fwd2_sel,
  output logic          halted,
  output logic [CW-1:0] stall_cnt
);

  typedef struct packed {
    logic          v;
    logic          wr;
    logic [RW-1:0] rd;
    logic          load;
  } sb_entry_t;

  sb_entry_t     sb_ex_q, sb_mem_q, sb_wb_q, sb_ex_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          halted_q;
  logic          run, hazard, flush_c, stall, halt_go;

  function automatic logic match(sb_entry_t s, logic [RW-1:0] r);
    logic zero_reg;
    zero_reg = R0_ZERO && (r == '0);
    return s.v && s.wr && (s.rd == r) && !zero_reg;
  endfunction

  // A load still in EX has no result yet, so it cannot be the forwarding source.
  function automatic logic [1:0] fwd_src(sb_entry_t ex, sb_entry_t mem, sb_entry_t wb,
                                         logic en, logic [RW-1:0] r);
    logic [1:0] sel;
    sel = 2'd0;
    if (en) begin
      if (match(ex, r) && !ex.load) begin
        sel = 2'd1;
      end else if (match(mem, r)) begin
        sel = 2'd2;
      end else if (match(wb, r)) begin
        sel = 2'd3;
      end
    end
    return sel;
  endfunction

  always_comb begin
    run     = exec & ~halted_q;
    hazard  = id_valid & sb_ex_q.load &
              ((id_use1 & match(sb_ex_q, id_rs1)) | (id_use2 & match(sb_ex_q, id_rs2)));
    flush_c = run & br_taken & sb_ex_q.v;
    stall   = run & ~flush_c & hazard;
    halt_go = run & ~flush_c & ~hazard & id_valid & id_halt;

    sb_ex_d.v    = id_valid & ~stall & ~flush_c;
    sb_ex_d.wr   = id_wr;
    sb_ex_d.rd   = id_rd;
    sb_ex_d.load = id_load;

    pc_d = pc_q + AW'(1);
    if (flush_c) begin
      pc_d = br_target;
    end else if (stall || halt_go) begin
      pc_d = pc_q;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb_ex_q     <= '0;
      sb_mem_q    <= '0;
      sb_wb_q     <= '0;
      pc_q        <= '0;
      stall_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else if (run) begin
      sb_wb_q     <= sb_mem_q;
      sb_mem_q    <= sb_ex_q;
      sb_ex_q     <= sb_ex_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      if (halt_go) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign pc           = pc_q;
  assign halted       = halted_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush        = flush_c;
  assign id_ex_bubble = stall;
  assign if_id_en     = run & ~stall & ~halt_go;
  assign fwd1_sel     = fwd_src(sb_ex_q, sb_mem_q, sb_wb_q, id_valid & id_use1, id_rs1);
  assign fwd2_sel     = fwd_src(sb_ex_q, sb_mem_q, sb_wb_q, id_valid & id_use2, id_rs2);

endmodule
